// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Pays out change in 5/2/1 zl coins from a local inventory, one coin at a
// time, using a greedy largest-coin-first selection with no backtracking.
// Each coin is handed to an external ejector with a req/ack handshake and is
// followed by a one-cycle gap before the next selection.
//
// Parameters
//   INIT_5, INIT_2, INIT_1 : coin counts loaded at reset and on refill
//
// Ports
//   clk            in   rising-edge system clock
//   reset          in   asynchronous active-low reset (0 = reset)
//   change_valid   in   one-cycle payout request, accepted only when idle
//   change_amount  in   [7:0] change owed in zl
//   refill         in   reload coin counters (idle only), clears fault
//   coin_ack       in   ejector has released the current coin
//   coin_req       out  coin ejection request
//   coin_out       out  [2:0] one-hot coin: 001=1 zl, 010=2 zl, 100=5 zl
//   busy           out  payout in progress
//   done           out  one-cycle pulse when the change is fully paid
//   fault          out  sticky: exact change impossible with the inventory
//   remaining      out  [7:0] change still owed
//   cnt5/cnt2/cnt1 out  [7:0] current coin inventory
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module change_dispenser #(
  parameter int INIT_5 = 10,
  parameter int INIT_2 = 10,
  parameter int INIT_1 = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       change_valid,
  input  logic [7:0] change_amount,
  input  logic       refill,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [2:0] coin_out,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining,
  output logic [7:0] cnt5,
  output logic [7:0] cnt2,
  output logic [7:0] cnt1
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_EJECT  = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_1    = 3'b001;
  localparam logic [2:0] COIN_2    = 3'b010;
  localparam logic [2:0] COIN_5    = 3'b100;

  localparam logic [7:0] INIT_5_C = 8'(INIT_5);
  localparam logic [7:0] INIT_2_C = 8'(INIT_2);
  localparam logic [7:0] INIT_1_C = 8'(INIT_1);

  logic [2:0] state_q,     state_d;
  logic       coin_req_q,  coin_req_d;
  logic [2:0] coin_out_q,  coin_out_d;
  logic       busy_q,      busy_d;
  logic       done_q,      done_d;
  logic       fault_q,     fault_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] cnt5_q,      cnt5_d;
  logic [7:0] cnt2_q,      cnt2_d;
  logic [7:0] cnt1_q,      cnt1_d;

  // Greedy pick for the current remaining amount and inventory. A
  // denomination with a zero count is never chosen, so the counters
  // cannot underflow on the following acknowledge.
  logic [2:0] pick;
  always_comb begin
    pick = COIN_NONE;
    if (remaining_q >= 8'd5 && cnt5_q != 8'd0) begin
      pick = COIN_5;
    end else if (remaining_q >= 8'd2 && cnt2_q != 8'd0) begin
      pick = COIN_2;
    end else if (remaining_q != 8'd0 && cnt1_q != 8'd0) begin
      pick = COIN_1;
    end
  end

  // Value in zl of the coin currently being ejected.
  logic [7:0] coin_value;
  always_comb begin
    case (coin_out_q)
      COIN_5:  coin_value = 8'd5;
      COIN_2:  coin_value = 8'd2;
      COIN_1:  coin_value = 8'd1;
      default: coin_value = 8'd0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no path
    // through the case statement can leave one unassigned (which would
    // infer a latch).
    state_d     = state_q;
    coin_req_d  = coin_req_q;
    coin_out_d  = coin_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    remaining_d = remaining_q;
    cnt5_d      = cnt5_q;
    cnt2_d      = cnt2_q;
    cnt1_d      = cnt1_q;

    case (state_q)
      ST_IDLE: begin
        if (refill) begin
          cnt5_d  = INIT_5_C;
          cnt2_d  = INIT_2_C;
          cnt1_d  = INIT_1_C;
          fault_d = 1'b0;
        end
        if (change_valid) begin
          remaining_d = change_amount;
          fault_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (pick != COIN_NONE) begin
          coin_out_d = pick;
          coin_req_d = 1'b1;
          state_d    = ST_EJECT;
        end else if (remaining_q == 8'd0) begin
          // done is raised on entry so it is visible during the DONE cycle.
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end
      end

      ST_EJECT: begin
        // coin_out and coin_req simply hold until the ejector acknowledges.
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value;
          case (coin_out_q)
            COIN_5:  cnt5_d = cnt5_q - 8'd1;
            COIN_2:  cnt2_d = cnt2_q - 8'd1;
            COIN_1:  cnt1_d = cnt1_q - 8'd1;
            default: ;
          endcase
          coin_req_d = 1'b0;
          coin_out_d = COIN_NONE;
          state_d    = ST_GAP;
        end
      end

      ST_GAP: begin
        state_d = ST_SELECT;
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        // remaining is left at the unpaid amount for the host to read.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        coin_req_d = 1'b0;
        coin_out_d = COIN_NONE;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // NOTE: the coin counters are ordinary flops, not a memory, so they take
  // their INIT values directly from reset; a payout interrupted by reset is
  // abandoned and the inventory is assumed restocked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      coin_req_q  <= 1'b0;
      coin_out_q  <= COIN_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      remaining_q <= 8'd0;
      cnt5_q      <= INIT_5_C;
      cnt2_q      <= INIT_2_C;
      cnt1_q      <= INIT_1_C;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      coin_req_q  <= coin_req_d;
      coin_out_q  <= coin_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      remaining_q <= remaining_d;
      cnt5_q      <= cnt5_d;
      cnt2_q      <= cnt2_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign coin_req  = coin_req_q;
  assign coin_out  = coin_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = remaining_q;
  assign cnt5      = cnt5_q;
  assign cnt2      = cnt2_q;
  assign cnt1      = cnt1_q;

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter INIT_5, default 10: number of 5 zl coins loaded at reset and on refill.
REQ-002 The block SHALL have parameter INIT_2, default 10: number of 2 zl coins loaded at reset and on refill.
REQ-003 The block SHALL have parameter INIT_1, default 10: number of 1 zl coins loaded at reset and on refill.
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock, rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous active-low reset (0 = reset).
REQ-006 The block SHALL have port change_valid, input, 1 bit: one-cycle request from vending_machine to pay change_amount.
REQ-007 The block SHALL have port change_amount, input, 8 bits: change owed, in zl, unsigned.
REQ-008 The block SHALL have port refill, input, 1 bit: reload all coin counters to INIT values.
REQ-009 The block SHALL have port coin_ack, input, 1 bit: ejector confirms the current coin has been released.
REQ-010 The block SHALL have port coin_req, output, 1 bit: coin ejection request.
REQ-011 The block SHALL have port coin_out, output, 3 bits: one-hot denomination, 001 = 1 zl, 010 = 2 zl, 100 = 5 zl (same encoding as Money_in).
REQ-012 The block SHALL have port busy, output, 1 bit: a payout is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when change is fully paid.
REQ-014 The block SHALL have port fault, output, 1 bit: sticky flag, exact change impossible with the current inventory.
REQ-015 The block SHALL have port remaining, output, 8 bits: change still owed.
REQ-016 The block SHALL have ports cnt5, cnt2 and cnt1, output, 8 bits each: current coin inventory.

Function
REQ-017 The FSM SHALL have states IDLE, SELECT, EJECT, GAP, DONE and FAULT, with all outputs registered.
REQ-018 In IDLE, change_valid=1 SHALL latch change_amount into remaining, clear fault, set busy=1 and enter SELECT on the next edge.
REQ-019 change_valid SHALL be ignored in every state other than IDLE.
REQ-020 SELECT SHALL pick a coin greedily in one cycle:
- 5 zl if remaining>=5 and cnt5>0;
- else 2 zl if remaining>=2 and cnt2>0;
- else 1 zl if remaining>=1 and cnt1>0.
REQ-021 When SELECT picks a coin, the FSM SHALL go to EJECT with coin_out set to that coin.
REQ-022 When SELECT finds remaining==0, the FSM SHALL go to DONE.
REQ-023 When SELECT finds no coin and remaining>0, the FSM SHALL go to FAULT.
REQ-024 In EJECT, coin_req SHALL be 1 and coin_out SHALL be held stable until coin_ack=1 is sampled.
REQ-025 On the coin_ack edge, remaining SHALL decrease by the coin value, the matching counter SHALL decrease by 1, and the FSM SHALL enter GAP.
REQ-026 In GAP, coin_req SHALL be 0 and coin_out SHALL be 000 for exactly one cycle, then the FSM SHALL return to SELECT.
REQ-027 coin_ack outside EJECT SHALL be ignored.
REQ-028 DONE SHALL assert done=1 for one cycle, clear busy and return to IDLE; a zero-amount request therefore pulses done 2 cycles after change_valid.
REQ-029 FAULT SHALL set fault=1, clear busy, keep remaining at the unpaid amount and return to IDLE.
REQ-030 fault SHALL stay set until the next accepted change_valid, a refill or a reset.
REQ-031 refill SHALL load the INIT values into the counters only in IDLE, and SHALL also clear fault; refill in any other state SHALL be ignored.
REQ-032 Counters SHALL never underflow; SELECT never picks a denomination whose count is 0.
REQ-033 Greedy selection is final: no backtracking (e.g. 6 zl with cnt1=0 pays 5 zl, then faults with remaining=1).
REQ-034 The count of coins per payout is unbounded; payout latency is 3 cycles per coin plus the coin_ack wait.

Reset
REQ-035 While reset=0, the block SHALL immediately force:
- state=IDLE;
- coin_req=0, coin_out=000, busy=0, done=0, fault=0;
- remaining=0;
- cnt5=INIT_5, cnt2=INIT_2, cnt1=INIT_1.
REQ-036 Reset asserted mid-EJECT SHALL drop coin_req at once and abandon the payout; counters SHALL be reloaded.
REQ-037 After reset releases, the first accepted change_valid SHALL be on the first rising edge that has reset=1.

Verification
REQ-038 Default inventory, change_amount=8, coin_ack returned 2 cycles after each coin_req -> coin_out 100, 010, 001 in order; done pulses; remaining=0; cnt5/cnt2/cnt1 = 9/9/9.
REQ-039 change_amount=0 -> no coin_req; done=1 exactly 2 cycles after change_valid; busy high for 2 cycles.
REQ-040 INIT_2=0, change_amount=4 -> four 001 coins; cnt1 = 6; done pulses.
REQ-041 INIT_1=0, change_amount=3 -> one 010 coin, then fault=1 with remaining=1 and busy=0; a later refill clears fault.
REQ-042 change_amount=7 is requested and a second change_valid (amount 5) arrives mid-payout -> the second request is ignored and exactly 5+2 is paid.
REQ-043 reset=0 is asserted while coin_req=1 -> coin_req=0 with no clock edge; counters return to INIT values; remaining=0.
